// File: rtl/mux_arb_pkg.sv
// Shared encodings for the 2:1 mux round-robin arbiter: FSM states and mux select values.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux_arb_hold_cnt.sv
// Saturating hold counter: counts consecutive grant cycles of the current owner, flags MAX_HOLD-1.
module mux_arb_hold_cnt #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_r;

  // Count register: clear wins over increment, increment stops at CNT_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_max = (cnt_r == CNT_MAX);

endmodule : mux_arb_hold_cnt

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux: grants one requester, drives sel, registers y/y_valid.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W        = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         grant_a,
  output logic         grant_b,
  output logic         sel,
  output logic [W-1:0] y,
  output logic         y_valid
);

  state_e state_r;
  state_e state_nxt_s;
  logic   last_r;
  logic   at_max_s;
  logic   cnt_clear_s;
  logic   cnt_inc_s;

  mux_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear_s),
    .inc    (cnt_inc_s),
    .at_max (at_max_s)
  );

  // Next-state logic; a waiting contender takes over once the owner reaches its hold limit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_a && req_b) begin
          state_nxt_s = (last_r == SEL_A) ? GRANT_B : GRANT_A;
        end else if (req_a) begin
          state_nxt_s = GRANT_A;
        end else if (req_b) begin
          state_nxt_s = GRANT_B;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          state_nxt_s = req_b ? GRANT_B : IDLE;
        end else if (req_b && at_max_s) begin
          state_nxt_s = GRANT_B;
        end else begin
          state_nxt_s = GRANT_A;
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_nxt_s = req_a ? GRANT_A : IDLE;
        end else if (req_a && at_max_s) begin
          state_nxt_s = GRANT_A;
        end else begin
          state_nxt_s = GRANT_B;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Hold counter control: restart on a new grant, advance while the same owner keeps the mux.
  always_comb begin
    cnt_clear_s = 1'b0;
    cnt_inc_s   = 1'b0;
    if (state_nxt_s != IDLE) begin
      cnt_clear_s = (state_nxt_s != state_r);
      cnt_inc_s   = (state_nxt_s == state_r);
    end else begin
      cnt_clear_s = 1'b0;
      cnt_inc_s   = 1'b0;
    end
  end

  // State, last-grantee, grant and select registers; sel keeps its value through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= SEL_B;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      sel     <= SEL_A;
    end else begin
      state_r <= state_nxt_s;
      grant_a <= (state_nxt_s == GRANT_A);
      grant_b <= (state_nxt_s == GRANT_B);
      if (state_nxt_s == GRANT_A) begin
        sel <= SEL_A;
      end else if (state_nxt_s == GRANT_B) begin
        sel <= SEL_B;
      end else begin
        sel <= sel;
      end
      if (cnt_clear_s) begin
        last_r <= (state_nxt_s == GRANT_B) ? SEL_B : SEL_A;
      end else begin
        last_r <= last_r;
      end
    end
  end

  // Data path: capture the granted input one cycle after the grant; y holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (state_r != IDLE) begin
      y       <= (state_r == GRANT_B) ? data_b : data_a;
      y_valid <= 1'b1;
    end else begin
      y       <= y;
      y_valid <= 1'b0;
    end
  end

endmodule : mux2_rr_arbiter

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter with a cycle model feeding an expected-value scoreboard.
module tb_mux2_rr_arbiter;

  localparam int W  = 2;
  localparam int MH = 4;

  typedef struct packed {
    logic         ga;
    logic         gb;
    logic         sel;
    logic [W-1:0] y;
    logic         valid;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_a = 1'b0;
  logic         req_b = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         grant_a, grant_b, sel, y_valid;
  logic [W-1:0] y;

  int checks = 0;
  int errors = 0;

  exp_t q[$];

  // Reference model state (0 idle, 1 A owns, 2 B owns; last: 0 = A, 1 = B)
  int           m_state = 0;
  int           m_last  = 1;
  int           m_cnt   = 0;
  logic         m_sel   = 1'b0;
  logic [W-1:0] m_y     = '0;
  logic         m_valid = 1'b0;

  mux2_rr_arbiter #(.W(W), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, predict the outputs after the next edge, then compare.
  task automatic step(input logic r, input logic ra, input logic rb,
                      input logic [W-1:0] da, input logic [W-1:0] db);
    int   ns;
    exp_t e;
    exp_t got;
    rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db;
    if (r) begin
      m_state = 0; m_last = 1; m_cnt = 0; m_sel = 1'b0; m_y = '0; m_valid = 1'b0;
    end else begin
      m_valid = (m_state != 0);
      if (m_state == 1) m_y = da;
      else if (m_state == 2) m_y = db;
      ns = m_state;
      if (m_state == 0) begin
        if (ra && rb) ns = (m_last == 1) ? 1 : 2;
        else if (ra) ns = 1;
        else if (rb) ns = 2;
      end else if (m_state == 1) begin
        if (!ra) ns = rb ? 2 : 0;
        else if (rb && m_cnt == MH - 1) ns = 2;
      end else begin
        if (!rb) ns = ra ? 1 : 0;
        else if (ra && m_cnt == MH - 1) ns = 1;
      end
      if (ns != 0 && ns != m_state) begin
        m_cnt  = 0;
        m_last = (ns == 2) ? 1 : 0;
      end else if (ns != 0) begin
        m_cnt = (m_cnt < MH - 1) ? m_cnt + 1 : m_cnt;
      end
      if (ns == 1) m_sel = 1'b0;
      else if (ns == 2) m_sel = 1'b1;
      m_state = ns;
    end
    e.ga = (m_state == 1); e.gb = (m_state == 2); e.sel = m_sel; e.y = m_y; e.valid = m_valid;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    check("grant_a", {1'b0, grant_a}, {1'b0, got.ga});
    check("grant_b", {1'b0, grant_b}, {1'b0, got.gb});
    check("sel", {1'b0, sel}, {1'b0, got.sel});
    check("y", y, got.y);
    check("y_valid", {1'b0, y_valid}, {1'b0, got.valid});
    check("grant_excl", {1'b0, grant_a & grant_b}, 2'b00);
  endtask

  initial begin
    // 1: reset held with both requests high, A wins the first tie
    step(1'b1, 1'b1, 1'b1, 2'b01, 2'b10);
    step(1'b1, 1'b1, 1'b1, 2'b01, 2'b10);
    check("rst_y_valid", {1'b0, y_valid}, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b01, 2'b10);
    check("post_rst_grant_a", {1'b0, grant_a}, 2'b01);
    step(1'b0, 1'b0, 1'b0, 2'b01, 2'b10);
    check("post_rst_y", y, 2'b01);
    step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // 2: single requester B, then release
    step(1'b0, 1'b0, 1'b1, 2'b00, 2'b10);
    check("single_sel", {1'b0, sel}, 2'b01);
    step(1'b0, 1'b0, 1'b1, 2'b00, 2'b10);
    check("single_y", y, 2'b10);
    step(1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    check("drop_grant_b", {1'b0, grant_b}, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    check("drop_y_valid", {1'b0, y_valid}, 2'b00);
    check("drop_sel_hold", {1'b0, sel}, 2'b01);

    // 3: continuous contention, A starts because B was last
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1, 1'b1, W'($urandom), W'($urandom));
      check("rot_grant_a", {1'b0, grant_a}, {1'b0, ((i / MH) % 2) == 0});
      check("rot_one_grant", {1'b0, grant_a ^ grant_b}, 2'b01);
    end
    step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // 4: late contender arrives on A's third grant cycle
    step(1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b10, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b11, 2'b01);
    check("late_a_4th", {1'b0, grant_a}, 2'b01);
    step(1'b0, 1'b1, 1'b1, 2'b10, 2'b01);
    check("late_b_grant", {1'b0, grant_b}, 2'b01);

    // 5: rotate back to A, then A drops while B waits
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, W'($urandom), W'($urandom));
    end
    check("handoff_a_owns", {1'b0, grant_a}, 2'b01);
    step(1'b0, 1'b0, 1'b1, 2'b00, 2'b11);
    check("handoff_gb", {1'b0, grant_b}, 2'b01);

    // 6: reset while B owns the mux with both requesting
    step(1'b0, 1'b1, 1'b1, 2'b01, 2'b11);
    step(1'b1, 1'b1, 1'b1, 2'b01, 2'b11);
    check("midrst_y", y, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b10, 2'b11);
    check("midrst_tie_a", {1'b0, grant_a}, 2'b01);
    step(1'b0, 1'b1, 1'b1, 2'b10, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux2_rr_arbiter

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter and select controller for the shared 2:1 mux datapath. Two requesters compete for the mux. The block grants one requester at a time, drives the mux select, and registers the selected data with a valid flag. A hold counter bounds how long one requester can keep the mux while the other is waiting, which guarantees fairness under continuous contention.

## Interface
Parameters:
- `W`, default 2: data width of each mux input and of `y`.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other requester waits. Legal range is ≥1.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `req_a`, input, 1: requester A wants the mux.
- `req_b`, input, 1: requester B wants the mux.
- `data_a`, input, W: mux input A.
- `data_b`, input, W: mux input B.
- `grant_a`, output, 1: registered grant to A.
- `grant_b`, output, 1: registered grant to B.
- `sel`, output, 1: mux select; 0 selects A, 1 selects B.
- `y`, output, W: registered mux output.
- `y_valid`, output, 1: `y` carries data from a granted requester.

## Operation
- Outputs after reset:
  - `grant_a`, `grant_b`, `sel`, `y_valid` = 0; `y` = 0.
  - Internal state: IDLE; `last` (last-granted requester) = B; `cnt` = 0.
- State machine has three states: IDLE, GRANT_A, GRANT_B.
- In IDLE:
  - Both requesting: grant the requester that is not `last`.
  - Only one requesting: go to that requester's grant state.
  - Neither requesting: stay in IDLE.
- In GRANT_A:
  - `req_a` = 0 and `req_b` = 1: go to GRANT_B directly, with no idle bubble.
  - `req_a` = 0 and `req_b` = 0: go to IDLE.
  - `req_a` = 1, `req_b` = 1, and `cnt` == MAX_HOLD-1: go to GRANT_B (forced rotation).
  - Otherwise: stay.
  - GRANT_B is the mirror image.
- On entering a grant state: `cnt` ← 0, `last` ← the new grantee. While staying in a grant state, `cnt` increments and saturates at MAX_HOLD-1.
- `grant_a` = (state == GRANT_A) and `grant_b` = (state == GRANT_B). They are never both 1.
- `sel` follows the grant state. In IDLE, `sel` holds its last value.
- `y` ← selected data and `y_valid` ← 1 on every edge where a grant is active. When no grant is active, `y_valid` ← 0 and `y` holds.
- With `MAX_HOLD` = 1 and both requesters active, the grant alternates every cycle.

## Timing
- Latency:
  - Request to grant: 1 cycle (a request sampled at edge n gives a grant after edge n).
  - Grant to `y_valid`: 1 further cycle.
  - `y` reflects `data_x` sampled on the edge where `grant_x` was already high.
- A grant drops one cycle after its request drops. `y_valid` drops one cycle after that.
- Under continuous contention each requester holds exactly MAX_HOLD cycles.
- Requests are level-sensitive; there is no acknowledge. A requester must keep `req` high until it sees its grant.
- If `rst` is asserted mid-grant, the next edge forces all reset values, whatever the requests are. A request held through reset is granted on the first edge after `rst` falls.

## Structure
- Package `mux_arb_pkg` holds:
  - the state encoding: IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2;
  - select constants: SEL_A = 1'b0, SEL_B = 1'b1.
- Sub-module `mux_arb_hold_cnt` is the saturating hold counter, with inputs `clear` and `inc` and output `at_max`. Its width is max(1, $clog2(MAX_HOLD)).
- The top level contains the FSM, the `last` register, and the output registers.

## Test plan
All scenarios use `MAX_HOLD` = 4 and `W` = 2.
1. Reset: hold `rst` for 2 cycles with both requests high. Required: all outputs 0 during reset. On the first edge after `rst` falls, `grant_a` = 1 and `sel` = 0. On the following edge, `y` = `data_a` and `y_valid` = 1.
2. Single requester: raise `req_b` only, with `data_b` = 2'b10. Required: `grant_b` and `sel` = 1 after 1 edge; `y` = 2'b10 and `y_valid` = 1 after 2 edges. Drop `req_b`: `grant_b` goes 0 after 1 edge, `y_valid` after 2, and `sel` stays 1.
3. Continuous contention: hold both requests high for 24 cycles. Required: grants run A×4, B×4, A×4, and so on. Never both grants high, and never a cycle with no grant.
4. Late contender: A is granted; `req_b` rises on A's third grant cycle. Required: A is held for 4 cycles in total, then B is granted with no gap.
5. Handoff: `req_a` drops while `req_b` is high. Required: `grant_b` is high on the very next cycle, with no IDLE cycle in between.
6. Reset mid-grant: assert `rst` while `grant_b` is high and both requests are high. Required: all outputs 0 on the next edge. After release, A is granted first on the tie, because `last` has been reset to B.
